// File: rtl/jtsdram_mbank_check_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : jtsdram_mbank_check_if
//  Purpose  : Bank request/response bundle between the multi-bank checker
//             (master) and the SDRAM controller bank ports (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface jtsdram_mbank_check_if #(
   parameter int BANKS = 4,
   parameter int AW    = 22,
   parameter int DW    = 16
);
   // One mask bit per byte lane, never narrower than one bit
   localparam int MW = (DW >= 8) ? DW/8 : 1;

   logic [BANKS*AW-1:0] ba_addr;
   logic [BANKS-1:0]    ba_rd;
   logic [BANKS-1:0]    ba_wr;
   logic [BANKS*DW-1:0] ba_din;
   logic [BANKS*MW-1:0] ba_din_m;
   logic [BANKS-1:0]    ba_ack;
   logic [BANKS-1:0]    ba_rdy;
   logic [DW-1:0]       data_read;

   modport master (
      output ba_addr, ba_rd, ba_wr, ba_din, ba_din_m,
      input  ba_ack, ba_rdy, data_read
   );

   modport slave (
      input  ba_addr, ba_rd, ba_wr, ba_din, ba_din_m,
      output ba_ack, ba_rdy, data_read
   );
endinterface
`default_nettype wire

// File: rtl/jtsdram_mbank_check.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : jtsdram_mbank_check
//  Purpose  : Parametrised multi-bank SDRAM read/write checker. Each bank
//             optionally writes an LFSR pattern over LEN words, reads it
//             back and compares, keeping sticky fail flags and saturating
//             error counters.
//  Options  : JTSDRAM_ERRLOG_EN - capture address/expected/read data of the
//             first mismatch per bank; otherwise first_* are tied to 0.
//  Revision : 1.0  initial release
// ============================================================================
module jtsdram_mbank_check #(
   parameter int          BANKS = 4,
   parameter int          AW    = 22,
   parameter int          DW    = 16,
   parameter int          LEN   = 1024,
   parameter logic [15:0] SEED  = 16'hACE1
) (
   input  wire logic              clk,
   input  wire logic              rst,
   input  wire logic              start,
   input  wire logic              wr_mode,
   input  wire logic              hold,
   output logic                   busy,
   output logic                   done,
   output logic [BANKS-1:0]       bad,
   output logic                   bad_any,
   output logic [BANKS*8-1:0]     err_cnt,
   output logic [BANKS*AW-1:0]    first_addr,
   output logic [BANKS*DW-1:0]    first_exp,
   output logic [BANKS*DW-1:0]    first_got,
   jtsdram_mbank_check_if.master  bus
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR_REQ  = 3'd1,
      ST_WR_WAIT = 3'd2,
      ST_RD_REQ  = 3'd3,
      ST_RD_WAIT = 3'd4,
      ST_FIN     = 3'd5
   } state_t;

   // Last word address of a phase; the counter never wraps past it
   localparam logic [AW-1:0] c_last = AW'(LEN - 1);

   // One step of the x^16+x^14+x^13+x^11+1 Fibonacci LFSR (shift right)
   function automatic logic [15:0] f_lfsr_step(input logic [15:0] s);
      return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
   endfunction

   // Map the 16-bit LFSR state onto DW bits: truncate or replicate
   function automatic logic [DW-1:0] f_widen(input logic [15:0] s);
      logic [DW-1:0] d;
      d = '0;
      for (int k = 0; k < DW; k++) d[k] = s[k % 16];
      return d;
   endfunction

   logic             r_busy;
   logic             r_done;
   logic             r_wr_mode;
   logic             w_start_ok;
   logic             w_all_fin;
   logic [BANKS-1:0] w_fin;

   assign w_start_ok = start & ~r_busy;
   assign w_all_fin  = &w_fin;

   assign busy    = r_busy;
   assign done    = r_done;
   assign bad_any = |bad;
   assign bus.ba_din_m = '0;

   // Pass control: accept start when idle, close the pass once every bank is in FIN
   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_wr_mode <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_start_ok) begin
            r_busy    <= 1'b1;
            r_wr_mode <= wr_mode;
         end else if (r_busy && w_all_fin) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
         end
      end
   end

   for (genvar b = 0; b < BANKS; b++) begin : g_bank
      localparam logic [15:0] c_seed_raw = SEED ^ 16'(b);
      // An all-zero LFSR would lock up, so a zero seed is replaced by 1
      localparam logic [15:0] c_seed     = (c_seed_raw == 16'h0000) ? 16'h0001 : c_seed_raw;

      state_t          r_state, w_state_nx;
      logic            r_pend,  w_pend_nx;
      logic [AW-1:0]   r_addr,  w_addr_nx;
      logic [15:0]     r_lfsr,  w_lfsr_nx;
      logic            r_bad;
      logic [7:0]      r_err;
      logic            w_step;
      logic            w_wr_ph;
      logic            w_cmp;
      logic            w_mis;
      logic [DW-1:0]   w_exp;

      assign w_wr_ph = (r_state == ST_WR_REQ) || (r_state == ST_WR_WAIT);
      assign w_exp   = f_widen(r_lfsr);
      assign w_cmp   = w_step & ~w_wr_ph;
      assign w_mis   = (bus.data_read != w_exp);
      assign w_fin[b] = (r_state == ST_FIN);

      assign bus.ba_rd[b]            = (r_state == ST_RD_REQ);
      assign bus.ba_wr[b]            = (r_state == ST_WR_REQ);
      assign bus.ba_addr[b*AW +: AW] = r_addr;
      assign bus.ba_din[b*DW +: DW]  = (r_state == ST_WR_REQ) ? w_exp : '0;
      assign bad[b]                  = r_bad;
      assign err_cnt[b*8 +: 8]       = r_err;

      // Bank sequencer: one outstanding access, REQ only issued while hold is low
      always_comb begin
         w_state_nx = r_state;
         w_pend_nx  = r_pend;
         w_addr_nx  = r_addr;
         w_lfsr_nx  = r_lfsr;
         w_step     = 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (r_busy && !hold) w_state_nx = r_wr_mode ? ST_WR_REQ : ST_RD_REQ;
            end
            ST_WR_REQ, ST_RD_REQ: begin
               if (bus.ba_ack[b]) begin
                  if (bus.ba_rdy[b]) begin
                     w_step = 1'b1;
                  end else begin
                     w_state_nx = (r_state == ST_WR_REQ) ? ST_WR_WAIT : ST_RD_WAIT;
                     w_pend_nx  = 1'b1;
                  end
               end
            end
            ST_WR_WAIT, ST_RD_WAIT: begin
               // Without a pending access the wait state just parks until hold drops
               if (r_pend) begin
                  if (bus.ba_rdy[b]) w_step = 1'b1;
               end else if (!hold) begin
                  w_state_nx = (r_state == ST_WR_WAIT) ? ST_WR_REQ : ST_RD_REQ;
               end
            end
            ST_FIN: begin
               if (r_busy && w_all_fin) w_state_nx = ST_IDLE;
            end
            default: w_state_nx = ST_IDLE;
         endcase

         if (w_step) begin
            w_pend_nx = 1'b0;
            if (r_addr == c_last) begin
               // Phase complete: restart address and pattern for the next phase
               w_addr_nx = '0;
               w_lfsr_nx = c_seed;
               if (w_wr_ph) w_state_nx = hold ? ST_RD_WAIT : ST_RD_REQ;
               else         w_state_nx = ST_FIN;
            end else begin
               w_addr_nx = r_addr + 1'b1;
               w_lfsr_nx = f_lfsr_step(r_lfsr);
               if (w_wr_ph) w_state_nx = hold ? ST_WR_WAIT : ST_WR_REQ;
               else         w_state_nx = hold ? ST_RD_WAIT : ST_RD_REQ;
            end
         end
      end

      // Bank state, pattern generator and mismatch statistics
      always_ff @(posedge clk) begin
         if (rst) begin
            r_state <= ST_IDLE;
            r_pend  <= 1'b0;
            r_addr  <= '0;
            r_lfsr  <= c_seed;
            r_bad   <= 1'b0;
            r_err   <= 8'd0;
         end else if (w_start_ok) begin
            r_state <= ST_IDLE;
            r_pend  <= 1'b0;
            r_addr  <= '0;
            r_lfsr  <= c_seed;
            r_bad   <= 1'b0;
            r_err   <= 8'd0;
         end else begin
            r_state <= w_state_nx;
            r_pend  <= w_pend_nx;
            r_addr  <= w_addr_nx;
            r_lfsr  <= w_lfsr_nx;
            if (w_cmp && w_mis) begin
               r_bad <= 1'b1;
               if (r_err != 8'hFF) r_err <= r_err + 8'd1;
            end
         end
      end

`ifdef JTSDRAM_ERRLOG_EN
      logic [AW-1:0] r_faddr;
      logic [DW-1:0] r_fexp;
      logic [DW-1:0] r_fgot;

      // Capture only the first mismatch of the pass; r_bad still low marks it
      always_ff @(posedge clk) begin
         if (rst || w_start_ok) begin
            r_faddr <= '0;
            r_fexp  <= '0;
            r_fgot  <= '0;
         end else if (w_cmp && w_mis && !r_bad) begin
            r_faddr <= r_addr;
            r_fexp  <= w_exp;
            r_fgot  <= bus.data_read;
         end
      end

      assign first_addr[b*AW +: AW] = r_faddr;
      assign first_exp[b*DW +: DW]  = r_fexp;
      assign first_got[b*DW +: DW]  = r_fgot;
`else
      assign first_addr[b*AW +: AW] = '0;
      assign first_exp[b*DW +: DW]  = '0;
      assign first_got[b*DW +: DW]  = '0;
`endif
   end

endmodule
`default_nettype wire

// File: tb/tb_jtsdram_mbank_check.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_jtsdram_mbank_check
//  Purpose  : Scoreboard bench for the multi-bank SDRAM checker with a
//             two-bank memory model sharing one read data bus.
//  Revision : 1.0  initial release
// ============================================================================
module tb_jtsdram_mbank_check;
   localparam int NB  = 2;
   localparam int AW  = 9;
   localparam int DW  = 16;
   localparam int LEN = 300;

   typedef struct packed {
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } req_t;

   typedef struct packed {
      logic [NB-1:0]    bad;
      logic [NB*8-1:0]  err;
      logic [NB*AW-1:0] faddr;
      logic [NB*DW-1:0] fxor;
   } res_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic              wr_mode = 1'b0;
   logic              hold = 1'b0;
   logic              busy, done, bad_any;
   logic [NB-1:0]     bad;
   logic [NB*8-1:0]   err_cnt;
   logic [NB*AW-1:0]  first_addr;
   logic [NB*DW-1:0]  first_exp, first_got;

   jtsdram_mbank_check_if #(.BANKS(NB), .AW(AW), .DW(DW)) bus ();

   jtsdram_mbank_check #(
      .BANKS(NB), .AW(AW), .DW(DW), .LEN(LEN), .SEED(16'hACE1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .wr_mode   (wr_mode),
      .hold      (hold),
      .busy      (busy),
      .done      (done),
      .bad       (bad),
      .bad_any   (bad_any),
      .err_cnt   (err_cnt),
      .first_addr(first_addr),
      .first_exp (first_exp),
      .first_got (first_got),
      .bus       (bus)
   );

   initial forever #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] pat [NB][LEN];
   logic [DW-1:0] mem [NB][512];
   req_t          exq [NB][$];
   res_t          resq[$];

   int   md = 0;          // 0 ideal, 1 flip bit0 bank1 addr5, 2 return inverted data
   bit   same = 1'b0;     // ack and rdy in the same cycle
   int   acc [NB];
   int   done_cnt = 0;
   logic          pend [NB];
   logic          pwr  [NB];
   logic [AW-1:0] paddr[NB];
   int   rr = 0;
   int   cyc = 0;
   bit   served;

   function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endfunction

   function automatic logic [15:0] lstep(input logic [15:0] s);
      logic fb;
      fb = s[0] ^ s[2] ^ s[3] ^ s[5];
      return {fb, s[15:1]};
   endfunction

   function automatic logic [DW-1:0] rdval(input int b, input logic [AW-1:0] a);
      logic [DW-1:0] v;
      v = mem[b][a];
      if (md == 1 && b == 1 && a == 5) v = v ^ 16'h0001;
      if (md == 2) v = ~v;
      return v;
   endfunction

   // Scoreboard side of an accepted request: compare against the next expected one
   function automatic void accept(input int b);
      req_t got, exp;
      got.wr   = bus.ba_wr[b];
      got.addr = bus.ba_addr[b*AW +: AW];
      got.data = bus.ba_wr[b] ? bus.ba_din[b*DW +: DW] : '0;
      if (exq[b].size() == 0) begin
         chk($sformatf("req_unexpected_b%0d", b), 64'(got), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
         exp = exq[b].pop_front();
         chk($sformatf("req_b%0d", b), 64'(got), 64'(exp));
      end
      chk($sformatf("din_m_b%0d", b), 64'(bus.ba_din_m), 64'd0);
      if (bus.ba_wr[b]) mem[b][bus.ba_addr[b*AW +: AW]] = bus.ba_din[b*DW +: DW];
      paddr[b] = bus.ba_addr[b*AW +: AW];
      pwr[b]   = bus.ba_wr[b];
      acc[b]++;
   endfunction

   // Memory model: one completion per cycle on the shared read bus
   always @(negedge clk) begin
      cyc++;
      bus.ba_ack    = '0;
      bus.ba_rdy    = '0;
      bus.data_read = '0;
      served = 1'b0;
      if (rst) begin
         for (int b = 0; b < NB; b++) pend[b] = 1'b0;
      end else if (!same) begin
         for (int i = 0; i < NB; i++) begin
            if (pend[(rr + i) % NB] && !served) begin
               bus.ba_rdy[(rr + i) % NB] = 1'b1;
               if (!pwr[(rr + i) % NB]) bus.data_read = rdval((rr + i) % NB, paddr[(rr + i) % NB]);
               pend[(rr + i) % NB] = 1'b0;
               served = 1'b1;
            end
         end
         rr = (rr + 1) % NB;
         for (int b = 0; b < NB; b++) begin
            if ((bus.ba_rd[b] || bus.ba_wr[b]) && !pend[b] && !bus.ba_rdy[b] && ((cyc + b) % 3 != 0)) begin
               bus.ba_ack[b] = 1'b1;
               accept(b);
               pend[b] = 1'b1;
            end
         end
      end else begin
         for (int i = 0; i < NB; i++) begin
            if ((bus.ba_rd[(rr + i) % NB] || bus.ba_wr[(rr + i) % NB]) && !served) begin
               bus.ba_ack[(rr + i) % NB] = 1'b1;
               bus.ba_rdy[(rr + i) % NB] = 1'b1;
               accept((rr + i) % NB);
               if (!pwr[(rr + i) % NB]) bus.data_read = rdval((rr + i) % NB, paddr[(rr + i) % NB]);
               served = 1'b1;
            end
         end
         rr = (rr + 1) % NB;
      end
   end

   // End-of-pass monitor: pop the expected pass result on every done pulse
   always @(negedge clk) begin
      res_t r;
      if (!rst && done) begin
         done_cnt++;
         if (resq.size() == 0) begin
            chk("done_unexpected", 64'(done), 64'd0);
         end else begin
            r = resq.pop_front();
            chk("done_busy", 64'(busy), 64'd0);
            chk("done_bad", 64'(bad), 64'(r.bad));
            chk("done_bad_any", 64'(bad_any), 64'(|r.bad));
            chk("done_err_cnt", 64'(err_cnt), 64'(r.err));
            for (int b = 0; b < NB; b++)
               chk($sformatf("done_left_b%0d", b), 64'(exq[b].size()), 64'd0);
`ifdef JTSDRAM_ERRLOG_EN
            chk("done_first_addr", 64'(first_addr), 64'(r.faddr));
            chk("done_first_xor", 64'(first_exp ^ first_got), 64'(r.fxor));
            for (int b = 0; b < NB; b++)
               chk($sformatf("done_first_exp_b%0d", b), 64'(first_exp[b*DW +: DW]),
                   r.bad[b] ? 64'(pat[b][r.faddr[b*AW +: AW]]) : 64'd0);
`else
            chk("done_first_addr", 64'(first_addr), 64'd0);
            chk("done_first_exp", 64'(first_exp), 64'd0);
            chk("done_first_got", 64'(first_got), 64'd0);
`endif
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic do_start(input logic wm, input logic hd, input res_t r);
      for (int b = 0; b < NB; b++) begin
         req_t q;
         exq[b].delete();
         acc[b] = 0;
         if (wm) for (int i = 0; i < LEN; i++) begin
            q.wr = 1'b1; q.addr = AW'(i); q.data = pat[b][i];
            exq[b].push_back(q);
         end
         for (int i = 0; i < LEN; i++) begin
            q.wr = 1'b0; q.addr = AW'(i); q.data = '0;
            exq[b].push_back(q);
         end
      end
      resq.push_back(r);
      start = 1'b1; wr_mode = wm; hold = hd;
      step();
      start = 1'b0;
   endtask

   task automatic wait_done(input string nm);
      int  c0;
      bit  got;
      c0  = done_cnt;
      got = 1'b0;
      for (int i = 0; i < 12000 && !got; i++) begin
         step();
         if (done_cnt != c0) got = 1'b1;
      end
      chk(nm, 64'(got), 64'd1);
   endtask

   initial begin
      res_t r;
      logic [15:0] s;
      bit   seen;
      int   dc;
      for (int b = 0; b < NB; b++) begin
         s = 16'hACE1 ^ 16'(b);
         for (int i = 0; i < LEN; i++) begin
            pat[b][i] = s;
            s = lstep(s);
         end
         for (int i = 0; i < 512; i++) mem[b][i] = '0;
         pend[b] = 1'b0; pwr[b] = 1'b0; paddr[b] = '0; acc[b] = 0;
      end

      // Reset state
      step(); step(); step();
      chk("rst_busy_done", 64'({busy, done}), 64'd0);
      chk("rst_bad", 64'({bad, bad_any}), 64'd0);
      chk("rst_err_cnt", 64'(err_cnt), 64'd0);
      chk("rst_req", 64'({bus.ba_rd, bus.ba_wr}), 64'd0);
      chk("rst_addr", 64'(bus.ba_addr), 64'd0);
      chk("rst_din", 64'(bus.ba_din), 64'd0);
      chk("rst_first", 64'(first_addr) | 64'(first_exp) | 64'(first_got), 64'd0);
      rst = 1'b0;
      step();

      // Write+read pass with an ideal memory; first request 2 cycles after start
      r = '0;
      do_start(1'b1, 1'b0, r);
      chk("lat_busy_c1", 64'(busy), 64'd1);
      chk("lat_noreq_c1", 64'({bus.ba_rd, bus.ba_wr}), 64'd0);
      step();
      chk("lat_req_c2", 64'(bus.ba_wr), 64'b11);
      chk("first_din_b0", 64'(bus.ba_din[0 +: DW]), 64'hACE1);
      chk("first_din_b1", 64'(bus.ba_din[DW +: DW]), 64'hACE0);
      wait_done("done_pass1");

      // Read-only pass, bank1 addr5 bit0 corrupted
      md = 1;
      r = '0;
      r.bad = 2'b10;
      r.err = {8'd1, 8'd0};
      r.faddr = {AW'(5), AW'(0)};
      r.fxor = {16'h0001, 16'h0000};
      do_start(1'b0, 1'b0, r);
      wait_done("done_pass_flip");
      md = 0;

      // hold high from start blocks all requests; release gives a request next cycle
      r = '0;
      do_start(1'b1, 1'b1, r);
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if ((|bus.ba_rd) || (|bus.ba_wr)) seen = 1'b1;
         step();
      end
      chk("hold_block", 64'(seen), 64'd0);
      chk("hold_busy", 64'(busy), 64'd1);
      hold = 1'b0;
      step();
      chk("hold_release", 64'(bus.ba_wr), 64'b11);
      wait_done("done_pass_hold");

      // Every read wrong: counters saturate at 255, done still pulses
      md = 2;
      r = '0;
      r.bad = 2'b11;
      r.err = {8'hFF, 8'hFF};
      r.faddr = '0;
      r.fxor = {16'hFFFF, 16'hFFFF};
      do_start(1'b0, 1'b0, r);
      wait_done("done_pass_sat");
      md = 0;

      // Reset in the middle of the read phase, then a fresh pass
      r = '0;
      do_start(1'b0, 1'b0, r);
      seen = 1'b0;
      for (int i = 0; i < 5000 && !seen; i++) begin
         if (bus.ba_rd[0] && bus.ba_addr[0 +: AW] == AW'(7)) seen = 1'b1;
         else step();
      end
      chk("abort_reach_word7", 64'(seen), 64'd1);
      dc = done_cnt;
      rst = 1'b1;
      for (int b = 0; b < NB; b++) exq[b].delete();
      resq.delete();
      step(); step();
      rst = 1'b0;
      step(); step();
      chk("abort_err_cnt", 64'(err_cnt), 64'd0);
      chk("abort_bad", 64'(bad), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_nodone", 64'(done_cnt), 64'(dc));
      r = '0;
      do_start(1'b0, 1'b0, r);
      step(); step(); step();
      start = 1'b1; wr_mode = 1'b1;
      step();
      start = 1'b0;
      wait_done("done_pass_restart");

      // ack and rdy together on every access
      same = 1'b1;
      r = '0;
      do_start(1'b1, 1'b0, r);
      wait_done("done_pass_same");
      chk("same_acc_b0", 64'(acc[0]), 64'(2*LEN));
      chk("same_acc_b1", 64'(acc[1]), 64'(2*LEN));
      same = 1'b0;

      step(); step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
